// File: rtl/led_matrix_scroller.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_scroller
// Purpose  : Drives a multiplexed ROWS x COLS LED matrix with a horizontally
//            scrolling message. For every row period the block first fetches
//            COLS column bitmaps from an external synchronous pattern memory.
//            It starts at the current scroll offset and keeps the row blanked
//            while it fetches. It then lights that row for the rest of the
//            period. Rising edges of the slow step clock advance the offset by
//            one column. The advance is applied only at a frame boundary, so a
//            frame never tears.
// Ports    : clk           system clock
//            rst_n         asynchronous active-low reset
//            enable_i      1 = scan, 0 = blank and park at row 0
//            step_clk_i    slow step clock, treated as an asynchronous level
//            mem_addr_o    pattern memory column address
//            mem_data_i    column bitmap, valid one cycle after mem_addr_o
//            row_sel_o     active-low one-hot row drive (all ones = blank)
//            col_data_o    active-high column drive, bit k = column offset+k
//            frame_start_o one-cycle pulse when the row 0 fetch begins
//            offset_o      current scroll offset
// Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scroller #(
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  parameter  int MSG_COLS = 64,
  parameter  int SCAN_DIV = 12_500,
  localparam int ADDR_W   = (MSG_COLS > 1) ? $clog2(MSG_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              step_clk_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [ROWS-1:0]   mem_data_i,
  output logic [ROWS-1:0]   row_sel_o,
  output logic [COLS-1:0]   col_data_o,
  output logic              frame_start_o,
  output logic [ADDR_W-1:0] offset_o
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  // One extra bit so offset + k never overflows before the modulo fold.
  localparam int SUM_W = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  FETCH_END = CNT_W'(COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(MSG_COLS - 1);
  localparam logic [SUM_W-1:0]  MSG_SUM   = SUM_W'(MSG_COLS);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,       state_d;
  logic [ROW_W-1:0]  row_idx_q,     row_idx_d;
  logic [CNT_W-1:0]  scan_cnt_q,    scan_cnt_d;
  logic [ADDR_W-1:0] offset_q,      offset_d;
  logic              step_pend_q,   step_pend_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [ROWS-1:0]   row_sel_q,     row_sel_d;
  logic [COLS-1:0]   col_data_q,    col_data_d;
  logic [COLS-1:0]   shadow_q,      shadow_d;
  logic              frame_start_q, frame_start_d;

  // Step clock synchroniser plus a previous-value flop for edge detection.
  logic              step_meta_q;
  logic              step_sync_q;
  logic              step_prev_q;

  logic              w_step_edge;
  logic [ADDR_W-1:0] w_offset_inc;
  logic [COLS-1:0]   w_shadow_cap;
  logic [ROWS-1:0]   w_row_drive;
  logic              w_frame_entry;
  logic [SUM_W-1:0]  w_sum;

  assign w_step_edge  = step_sync_q & ~step_prev_q;
  assign w_offset_inc = (offset_q == LAST_COL) ? '0 : offset_q + ADDR_W'(1);

  // In fetch cycle k+1 the memory returns the column addressed in cycle k.
  // Merge that bit into the shadow. The row can then latch the full bitmap
  // on the same edge that captures its last column.
  always_comb begin
    w_shadow_cap = shadow_q;
    for (int k = 0; k < COLS; k++) begin
      if (scan_cnt_q == CNT_W'(k + 1)) begin
        w_shadow_cap[k] = mem_data_i[row_idx_q];
      end
    end
  end

  // Active-low drive for the row being fetched; exactly one bit low.
  always_comb begin
    w_row_drive = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (row_idx_q == ROW_W'(r)) begin
        w_row_drive[r] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    row_idx_d     = row_idx_q;
    scan_cnt_d    = scan_cnt_q;
    offset_d      = offset_q;
    step_pend_d   = step_pend_q | w_step_edge;
    mem_addr_d    = mem_addr_q;
    row_sel_d     = row_sel_q;
    col_data_d    = col_data_q;
    shadow_d      = shadow_q;
    frame_start_d = 1'b0;
    w_frame_entry = 1'b0;
    w_sum         = '0;

    case (state_q)
      ST_IDLE: begin
        row_sel_d  = '1;
        col_data_d = '0;
        if (enable_i) begin
          state_d       = ST_FETCH;
          row_idx_d     = '0;
          scan_cnt_d    = '0;
          w_frame_entry = 1'b1;
        end
      end

      ST_FETCH: begin
        // The row stays blank while the next bitmap is gathered.
        row_sel_d  = '1;
        shadow_d   = w_shadow_cap;
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        if (scan_cnt_q == FETCH_END) begin
          state_d    = ST_SHOW;
          col_data_d = w_shadow_cap;
          row_sel_d  = w_row_drive;
        end
      end

      ST_SHOW: begin
        if (scan_cnt_q == LAST_CNT) begin
          state_d    = ST_FETCH;
          scan_cnt_d = '0;
          row_sel_d  = '1;
          col_data_d = '0;
          if (row_idx_q == LAST_ROW) begin
            row_idx_d     = '0;
            w_frame_entry = 1'b1;
          end else begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end
        end else begin
          scan_cnt_d = scan_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        row_idx_d  = '0;
        scan_cnt_d = '0;
        row_sel_d  = '1;
        col_data_d = '0;
      end
    endcase

    // Disable wins from any state. The offset and any pending step survive.
    if (!enable_i) begin
      state_d       = ST_IDLE;
      row_idx_d     = '0;
      scan_cnt_d    = '0;
      row_sel_d     = '1;
      col_data_d    = '0;
      w_frame_entry = 1'b0;
    end

    // Frame boundary: consume a pending step so the whole frame uses the new
    // offset. A fresh edge arriving in the same cycle stays pending.
    if (w_frame_entry) begin
      frame_start_d = 1'b1;
      if (step_pend_q) begin
        offset_d    = w_offset_inc;
        step_pend_d = w_step_edge;
      end
    end

    // The address is registered. It is computed from the next-cycle offset and
    // counter, so fetch cycle k already presents offset+k.
    if ((state_d == ST_FETCH) && (scan_cnt_d < FETCH_END)) begin
      w_sum = SUM_W'(offset_d) + SUM_W'(scan_cnt_d);
      if (w_sum >= MSG_SUM) begin
        w_sum = w_sum - MSG_SUM;
      end
      mem_addr_d = w_sum[ADDR_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      row_idx_q     <= '0;
      scan_cnt_q    <= '0;
      offset_q      <= '0;
      step_pend_q   <= 1'b0;
      mem_addr_q    <= '0;
      row_sel_q     <= '1;
      col_data_q    <= '0;
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
      step_meta_q   <= 1'b0;
      step_sync_q   <= 1'b0;
      step_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      scan_cnt_q    <= scan_cnt_d;
      offset_q      <= offset_d;
      step_pend_q   <= step_pend_d;
      mem_addr_q    <= mem_addr_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      step_meta_q   <= step_clk_i;
      step_sync_q   <= step_meta_q;
      step_prev_q   <= step_sync_q;
    end
  end

  assign mem_addr_o    = mem_addr_q;
  assign row_sel_o     = row_sel_q;
  assign col_data_o    = col_data_q;
  assign frame_start_o = frame_start_q;
  assign offset_o      = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_scroller
// Purpose  : Self-checking bench for led_matrix_scroller. It uses ROWS=8,
//            COLS=8, MSG_COLS=64 and SCAN_DIV=16, with a synchronous pattern
//            memory model. Expected values come from the scan timeline: cycle t
//            of a frame is row t/16, phase t%16. Phases 0..8 are blank and the
//            row is lit from phase 9. The expected offset follows the count of
//            consumed step edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scroller;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int MSG_COLS = 64;
  localparam int SCAN_DIV = 16;
  localparam int ADDR_W   = 6;
  localparam int FRAME    = ROWS * SCAN_DIV;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              enable   = 1'b0;
  logic              step_clk = 1'b0;
  logic [ROWS-1:0]   mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROWS-1:0]   row_sel;
  logic [COLS-1:0]   col_data;
  logic              frame_start;
  logic [ADDR_W-1:0] offset;

  logic [ROWS-1:0]   mem [MSG_COLS];
  int                tests_run    = 0;
  int                tests_failed = 0;
  int                exp_offset   = 0;

  always #5 clk = ~clk;

  // Synchronous pattern memory: data follows the address by one cycle.
  always @(posedge clk) mem_data <= mem[mem_addr];

  led_matrix_scroller #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .MSG_COLS (MSG_COLS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .step_clk_i    (step_clk),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .row_sel_o     (row_sel),
    .col_data_o    (col_data),
    .frame_start_o (frame_start),
    .offset_o      (offset)
  );

  // Reference: row r lit with columns (o+k) mod MSG_COLS, bit r of each.
  function automatic logic [COLS-1:0] exp_cols(input int o, input int r);
    logic [COLS-1:0] v;
    logic [ROWS-1:0] w;
    for (int k = 0; k < COLS; k++) begin
      w    = mem[(o + k) % MSG_COLS];
      v[k] = w[r];
    end
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_rowsel(input int r);
    logic [ROWS-1:0] v;
    v    = '1;
    v[r] = 1'b0;
    return v;
  endfunction

  // Park in IDLE, then re-enable. On return the sample point is frame cycle 0.
  task automatic restart_scan();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (row_sel !== 8'hFF || col_data !== 8'h00 || frame_start !== 1'b0 ||
        offset !== 6'd0 || mem_addr !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset: row_sel=%h col=%h fs=%b off=%0d addr=%0d required FF 00 0 0 0",
               row_sel, col_data, frame_start, offset, mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp_offset = 0;
  endtask

  task automatic test_frame_scan(input bit use_random);
    for (int c = 0; c < MSG_COLS; c++) mem[c] = use_random ? ROWS'($urandom) : ROWS'(c);
    restart_scan();
    for (int t = 0; t <= 2 * FRAME; t++) begin
      int r = (t / SCAN_DIV) % ROWS;
      int j = t % SCAN_DIV;
      logic exp_fs = (j == 0) && (r == 0);
      tests_run++;
      if (frame_start !== exp_fs) begin
        tests_failed++;
        $display("FAIL scan.frame_start t=%0d: got %b required %b", t, frame_start, exp_fs);
      end
      if (j < COLS) begin
        tests_run++;
        if (mem_addr !== ADDR_W'((exp_offset + j) % MSG_COLS)) begin
          tests_failed++;
          $display("FAIL scan.mem_addr t=%0d: got %0d required %0d", t, mem_addr,
                   (exp_offset + j) % MSG_COLS);
        end
      end
      tests_run++;
      if (j <= COLS) begin
        if (row_sel !== 8'hFF) begin
          tests_failed++;
          $display("FAIL scan.blank t=%0d: row_sel got %h required FF", t, row_sel);
        end
      end else if (row_sel !== exp_rowsel(r) || col_data !== exp_cols(exp_offset, r)) begin
        tests_failed++;
        $display("FAIL scan.row t=%0d: row_sel/col got %h/%h required %h/%h", t, row_sel,
                 col_data, exp_rowsel(r), exp_cols(exp_offset, r));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_step();
    int s = $urandom_range(16, 90);
    int o0 = exp_offset;
    int o1 = (exp_offset + 1) % MSG_COLS;
    for (int c = 0; c < MSG_COLS; c++) mem[c] = ROWS'($urandom);
    restart_scan();
    for (int t = 0; t <= 2 * FRAME; t++) begin
      int r = (t / SCAN_DIV) % ROWS;
      int j = t % SCAN_DIV;
      int eo = (t < FRAME) ? o0 : o1;
      tests_run++;
      if (offset !== ADDR_W'(eo) || frame_start !== ((j == 0) && (r == 0))) begin
        tests_failed++;
        $display("FAIL step.offset t=%0d: got off=%0d fs=%b required off=%0d", t, offset,
                 frame_start, eo);
      end
      if (t >= FRAME && t < FRAME + SCAN_DIV && j < COLS) begin
        tests_run++;
        if (mem_addr !== ADDR_W'((o1 + j) % MSG_COLS)) begin
          tests_failed++;
          $display("FAIL step.mem_addr t=%0d: got %0d required %0d", t, mem_addr,
                   (o1 + j) % MSG_COLS);
        end
      end
      if (t >= FRAME && j > COLS) begin
        tests_run++;
        if (col_data !== exp_cols(o1, r)) begin
          tests_failed++;
          $display("FAIL step.col t=%0d: got %h required %h", t, col_data, exp_cols(o1, r));
        end
      end
      if (t == s) step_clk = 1'b1;
      if (t == s + 6) step_clk = 1'b0;
      @(negedge clk);
    end
    exp_offset = o1;
  endtask

  task automatic test_burst();
    int s = $urandom_range(10, 60);
    int o0 = exp_offset;
    int o1 = (exp_offset + 1) % MSG_COLS;
    restart_scan();
    for (int t = 0; t <= 2 * FRAME; t++) begin
      int eo = (t < FRAME) ? o0 : o1;
      tests_run++;
      if (offset !== ADDR_W'(eo)) begin
        tests_failed++;
        $display("FAIL burst.offset t=%0d: got %0d required %0d", t, offset, eo);
      end
      for (int p = 0; p < 3; p++) begin
        if (t == s + 8 * p) step_clk = 1'b1;
        if (t == s + 8 * p + 4) step_clk = 1'b0;
      end
      @(negedge clk);
    end
    exp_offset = o1;
  endtask

  task automatic test_enable_drop();
    int d;
    int hold;
    for (int phase = 0; phase < 2; phase++) begin
      // Phase 0 drops during the row 3 fetch, phase 1 while row 2 is lit.
      d    = (phase == 0) ? 3 * SCAN_DIV + $urandom_range(0, COLS) : 2 * SCAN_DIV + 12;
      hold = $urandom_range(3, 6);
      restart_scan();
      for (int t = 0; t < d; t++) @(negedge clk);
      tests_run++;
      if (row_sel !== ((phase == 0) ? 8'hFF : exp_rowsel(2))) begin
        tests_failed++;
        $display("FAIL drop.before phase=%0d: row_sel got %h", phase, row_sel);
      end
      enable = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        tests_run++;
        if (row_sel !== 8'hFF || col_data !== 8'h00 || frame_start !== 1'b0 ||
            offset !== ADDR_W'(exp_offset)) begin
          tests_failed++;
          $display("FAIL drop.blank phase=%0d: row_sel=%h col=%h fs=%b off=%0d required FF 00 0 %0d",
                   phase, row_sel, col_data, frame_start, offset, exp_offset);
        end
      end
      enable = 1'b1;
      for (int t = 0; t <= COLS + 1; t++) begin
        @(negedge clk);
        tests_run++;
        if (frame_start !== (t == 0) || offset !== ADDR_W'(exp_offset)) begin
          tests_failed++;
          $display("FAIL drop.reenable t=%0d: fs=%b off=%0d required fs=%b off=%0d", t,
                   frame_start, offset, (t == 0), exp_offset);
        end
        if (t < COLS) begin
          tests_run++;
          if (mem_addr !== ADDR_W'((exp_offset + t) % MSG_COLS)) begin
            tests_failed++;
            $display("FAIL drop.mem_addr t=%0d: got %0d required %0d", t, mem_addr,
                     (exp_offset + t) % MSG_COLS);
          end
        end
      end
      tests_run++;
      if (row_sel !== 8'hFE || col_data !== exp_cols(exp_offset, 0)) begin
        tests_failed++;
        $display("FAIL drop.row0: row_sel/col got %h/%h required FE/%h", row_sel, col_data,
                 exp_cols(exp_offset, 0));
      end
    end
  endtask

  task automatic test_async_reset();
    restart_scan();
    for (int t = 0; t < 2 * SCAN_DIV + 12; t++) @(negedge clk);
    tests_run++;
    if (row_sel !== exp_rowsel(2) || offset !== ADDR_W'(exp_offset)) begin
      tests_failed++;
      $display("FAIL areset.before: row_sel=%h off=%0d required %h %0d", row_sel, offset,
               exp_rowsel(2), exp_offset);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (row_sel !== 8'hFF || col_data !== 8'h00 || offset !== 6'd0 || frame_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset.immediate: row_sel=%h col=%h off=%0d fs=%b required FF 00 0 0",
               row_sel, col_data, offset, frame_start);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    exp_offset = 0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int eo;
    int r;
    int j;
    for (int c = 0; c < MSG_COLS; c++) mem[c] = ROWS'($urandom);
    // Advance quickly to offset 62: each re-enable is a frame boundary.
    while (exp_offset < 62) begin
      step_clk = 1'b1;
      repeat (4) @(negedge clk);
      step_clk = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      exp_offset++;
      tests_run++;
      if (frame_start !== 1'b1 || offset !== ADDR_W'(exp_offset)) begin
        tests_failed++;
        $display("FAIL wrap.advance: fs=%b off=%0d required 1 %0d", frame_start, offset,
                 exp_offset);
      end
      enable = 1'b0;
      @(negedge clk);
    end
    restart_scan();
    for (int t = 0; t < 2 * FRAME + SCAN_DIV; t++) begin
      r  = (t / SCAN_DIV) % ROWS;
      j  = t % SCAN_DIV;
      eo = (62 + t / FRAME) % MSG_COLS;
      tests_run++;
      if (offset !== ADDR_W'(eo)) begin
        tests_failed++;
        $display("FAIL wrap.offset t=%0d: got %0d required %0d", t, offset, eo);
      end
      if (j < COLS && r == 0) begin
        tests_run++;
        if (mem_addr !== ADDR_W'((eo + j) % MSG_COLS)) begin
          tests_failed++;
          $display("FAIL wrap.mem_addr t=%0d: got %0d required %0d", t, mem_addr,
                   (eo + j) % MSG_COLS);
        end
      end
      if (j > COLS) begin
        tests_run++;
        if (col_data !== exp_cols(eo, r) || row_sel !== exp_rowsel(r)) begin
          tests_failed++;
          $display("FAIL wrap.row t=%0d: col/row_sel got %h/%h required %h/%h", t, col_data,
                   row_sel, exp_cols(eo, r), exp_rowsel(r));
        end
      end
      if (t == 30 || t == FRAME + 30) step_clk = 1'b1;
      if (t == 36 || t == FRAME + 36) step_clk = 1'b0;
      @(negedge clk);
    end
    exp_offset = 0;
  endtask

  initial begin
    test_reset();
    test_frame_scan(1'b0);
    test_frame_scan(1'b1);
    test_step();
    test_burst();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
